pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Instruction-sequencing controller for the single-issue processor core. It owns the architectural PC and issues fetch requests to instruction memory over a valid/ready handshake. It presents each fetched word to decode/execute, then commits the next-PC and exception result from the flow-control datapath. On an exception or fetch timeout it enters a sticky halt state.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
TIMEOUT_CYCLES, 255, maximum FETCH_WAIT cycles without a response before halting; range 1..65535.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst_n  input  1  synchronous reset, active-low.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  instruction memory accepts request.
imem_addr  output  32  fetch address; equals pc.
imem_rsp_valid  input  1  fetch response valid.
imem_rsp_data  input  32  fetched instruction word.
instr  output  32  registered instruction for decode/execute.
instr_valid  output  1  1-cycle pulse: instr is new.
exec_done  input  1  execute finished; new_pc and exception are valid this cycle.
new_pc  input  32  next PC from flow control.
exception  input  1  flow-control/execute exception.
pc  output  32  PC of the current instruction.
retired  output  32  committed-instruction counter.
halted  output  1  sticky halt flag.
halt_cause  output  2  0 = none, 1 = exception or misaligned new_pc, 2 = fetch timeout.
redirect_count  output  32  see Optional Feature.

Behaviour:
- States: FETCH_REQ, FETCH_WAIT, EXECUTE, HALT.
- Reset (rst_n = 0 at a clock edge) overrides every other event, including mid-transaction:
  - state = FETCH_REQ, pc = RESET_PC, imem_addr = RESET_PC.
  - imem_req_valid = 0 in the reset cycle.
  - instr = 0, instr_valid = 0, retired = 0, halted = 0, halt_cause = 0, redirect_count = 0, timeout counter = 0.
- FETCH_REQ:
  - imem_req_valid = 1, imem_addr = pc.
  - Both are held stable until imem_req_ready = 1.
  - On valid & ready: go to FETCH_WAIT, clear the timeout counter.
- FETCH_WAIT:
  - imem_req_valid = 0.
  - Responses are sampled only in this state; the earliest is 1 cycle after acceptance. imem_rsp_valid in any other state is ignored.
  - On imem_rsp_valid: instr <= imem_rsp_data, go to EXECUTE. instr_valid = 1 for exactly the first EXECUTE cycle.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES: go to HALT, halt_cause = 2.
  - A response arriving in the same cycle the counter hits the limit wins; no halt.
- EXECUTE:
  - Waits for exec_done. exec_done may be asserted in the same cycle as instr_valid.
  - On exec_done with exception = 1 or new_pc[1:0] != 0: go to HALT, halt_cause = 1. pc keeps the faulting instruction's address; retired does not increment.
  - On exec_done otherwise: pc <= new_pc, retired <= retired + 1 (wraps 32'hFFFF_FFFF -> 0), go to FETCH_REQ.
  - imem_req_valid rises the cycle after exec_done.
- Throughput: minimum 3 cycles per instruction (REQ accepted, WAIT with response, EXECUTE with exec_done).
- HALT:
  - halted = 1, imem_req_valid = 0.
  - exec_done and imem_rsp_valid are ignored.
  - Only reset exits.
- Stale responses to a request issued before a mid-operation reset are not filtered. Instruction memory shares rst_n and must drop them.

Optional Feature:
Macro PC_SEQ_REDIRECT_STATS_EN.
- Defined: redirect_count increments (wrapping) on each non-halting commit where new_pc != pc + 4, i.e. a taken branch/jump.
- Not defined: redirect_count is tied to 32'h0 and no counter logic is synthesized. All other behaviour is identical.

Test Plan:
- Reset release, RESET_PC = 32'h100, memory always ready with 1-cycle response, exec_done on every instr_valid cycle, new_pc = pc + 4 -> imem_addr sequence 100, 104, 108 every 3 cycles; retired = 3 after three commits.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid stays 1 and imem_addr stable; accepted on cycle 6.
- In EXECUTE at pc = 32'h200, new_pc = 32'h180, exception = 0 -> next imem_addr = 32'h180; redirect_count increments to 1 only when PC_SEQ_REDIRECT_STATS_EN is defined, else stays 0.
- exec_done with exception = 1 at pc = 32'h40 (and separately new_pc = 32'h42) -> halted = 1, halt_cause = 1, pc = 32'h40, no further imem_req_valid, retired unchanged.
- TIMEOUT_CYCLES = 4, no response -> halted = 1, halt_cause = 2 after 4 WAIT cycles. Response on exactly the 4th cycle -> no halt, instr_valid pulses.
- rst_n low during EXECUTE with exec_done = 1 -> commit discarded, pc = RESET_PC, retired = 0; fetch restarts 1 cycle after rst_n returns high.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction sequencer: PC ownership, fetch handshake, commit, sticky halt
// Optional redirect statistics enabled by defining PC_SEQ_REDIRECT_STATS_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [31:0] new_pc,
  input  logic        exception,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] redirect_count
);

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    EXECUTE    = 2'd2,
    HALT       = 2'd3
  } state_t;

  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        req_valid_q;
  logic        accept;
  logic        fault;
  logic        timeout_hit;

  // Request valid is registered so it stays low in the reset cycle and rises one cycle after commit.
  assign accept         = req_valid_q & imem_req_ready;
  assign fault          = exception | (new_pc[1:0] != 2'b00);
  assign timeout_hit    = ({1'b0, wait_cnt} + 17'd1) >= TIMEOUT_LIM;
  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc;
  assign halted         = (state == HALT);

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_REQ: begin
        if (accept) state_nxt = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        // A response in the same cycle the limit is reached takes priority over the timeout.
        if (imem_rsp_valid)   state_nxt = EXECUTE;
        else if (timeout_hit) state_nxt = HALT;
      end
      EXECUTE: begin
        if (exec_done) state_nxt = fault ? HALT : FETCH_REQ;
      end
      default: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH_REQ;
      req_valid_q <= 1'b0;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      retired     <= 32'h0;
      halt_cause  <= 2'd0;
      wait_cnt    <= 16'h0;
    end else begin
      state       <= state_nxt;
      req_valid_q <= (state_nxt == FETCH_REQ);
      instr_valid <= 1'b0;
      case (state)
        FETCH_REQ: begin
          if (accept) wait_cnt <= 16'h0;
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            instr       <= imem_rsp_data;
            instr_valid <= 1'b1;
          end else if (timeout_hit) begin
            halt_cause <= 2'd2;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        EXECUTE: begin
          if (exec_done) begin
            if (fault) begin
              halt_cause <= 2'd1;
            end else begin
              pc      <= new_pc;
              retired <= retired + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PC_SEQ_REDIRECT_STATS_EN
  logic [31:0] redirect_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_q <= 32'h0;
    end else if (state == EXECUTE && exec_done && !fault && new_pc != pc + 32'd4) begin
      redirect_q <= redirect_q + 32'd1;
    end
  end

  assign redirect_count = redirect_q;
`else
  assign redirect_count = 32'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic [31:0] new_pc;
  logic        exception;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] redirect_count;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h100), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .new_pc(new_pc), .exception(exception),
    .pc(pc), .retired(retired), .halted(halted), .halt_cause(halt_cause),
    .redirect_count(redirect_count)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_retired;
  logic [31:0] exp_redir;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    exec_done = 1'b0; new_pc = 32'h0; exception = 1'b0;
    step(); step();
    addr_q.delete(); instr_q.delete();
    exp_pc = 32'h100; exp_retired = 32'h0; exp_redir = 32'h0;
    check("rst_pc", pc, exp_pc);
    check("rst_addr", imem_addr, exp_pc);
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_halt_cause", {30'h0, halt_cause}, 32'h0);
    check("rst_redirect", redirect_count, 32'h0);
    rst_n = 1'b1;
    step();
    check("restart_req_valid", {31'h0, imem_req_valid}, 32'h1);
    addr_q.push_back(32'h100);
  endtask

  task automatic issue_fetch(input int ready_delay, input int rsp_delay, input logic [31:0] data);
    int budget = 0;
    while (!imem_req_valid && budget < 20) begin
      step();
      budget++;
    end
    check("req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("imem_addr", imem_addr, addr_q.pop_front());
    for (int i = 0; i < ready_delay; i++) begin
      imem_req_ready = 1'b0;
      step();
      check("req_hold_valid", {31'h0, imem_req_valid}, 32'h1);
      check("req_hold_addr", imem_addr, exp_pc);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("req_drop", {31'h0, imem_req_valid}, 32'h0);
    for (int i = 0; i < rsp_delay; i++) begin
      step();
      check("wait_not_halted", {31'h0, halted}, 32'h0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    instr_q.push_back(data);
    step();
    imem_rsp_valid = 1'b0;
    check("instr_valid", {31'h0, instr_valid}, 32'h1);
    check("instr", instr, instr_q.pop_front());
    check("exec_pc", pc, exp_pc);
  endtask

  task automatic commit(input logic [31:0] npc, input logic exc);
    exec_done = 1'b1; new_pc = npc; exception = exc;
    step();
    exec_done = 1'b0; exception = 1'b0;
    check("instr_valid_pulse", {31'h0, instr_valid}, 32'h0);
    if (exc || npc[1:0] != 2'b00) begin
      check("fault_halted", {31'h0, halted}, 32'h1);
      check("fault_cause", {30'h0, halt_cause}, 32'h1);
      check("fault_pc", pc, exp_pc);
      check("fault_retired", retired, exp_retired);
      check("fault_req_valid", {31'h0, imem_req_valid}, 32'h0);
    end else begin
`ifdef PC_SEQ_REDIRECT_STATS_EN
      if (npc != exp_pc + 32'd4) exp_redir++;
`endif
      exp_retired++;
      exp_pc = npc;
      addr_q.push_back(npc);
      check("commit_halted", {31'h0, halted}, 32'h0);
      check("commit_pc", pc, exp_pc);
      check("commit_retired", retired, exp_retired);
      check("commit_redirect", redirect_count, exp_redir);
      check("commit_req_valid", {31'h0, imem_req_valid}, 32'h1);
    end
  endtask

  task automatic check_stays_halted(input logic [1:0] cause);
    for (int i = 0; i < 4; i++) begin
      imem_rsp_valid = 1'b1; exec_done = 1'b1; new_pc = 32'h300; imem_req_ready = 1'b1;
      step();
      check("halt_req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("halt_sticky", {31'h0, halted}, 32'h1);
      check("halt_cause_sticky", {30'h0, halt_cause}, {30'h0, cause});
      check("halt_instr_valid", {31'h0, instr_valid}, 32'h0);
      check("halt_retired", retired, exp_retired);
    end
    imem_rsp_valid = 1'b0; exec_done = 1'b0; imem_req_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    do_reset();

    // Back-to-back sequential fetches at three cycles per instruction.
    for (int k = 0; k < 3; k++) begin
      t0 = cyc;
      issue_fetch(0, 0, 32'hA000_0000 + k);
      commit(exp_pc + 32'd4, 1'b0);
      check("cpi", cyc - t0, 32'd3);
    end
    check("retired_three", retired, 32'd3);

    // Ready stall, then redirects through 0x200 -> 0x180 -> 0x40, then exception at 0x40.
    issue_fetch(5, 0, 32'hB000_0001);
    commit(32'h200, 1'b0);
    issue_fetch(0, 0, 32'hB000_0002);
    commit(32'h180, 1'b0);
    issue_fetch(0, 0, 32'hB000_0003);
    commit(32'h40, 1'b0);
    issue_fetch(0, 0, 32'hB000_0004);
    commit(32'h44, 1'b1);
    check_stays_halted(2'd1);

    // Misaligned new_pc at 0x40.
    do_reset();
    issue_fetch(0, 0, 32'hC000_0001);
    commit(32'h40, 1'b0);
    issue_fetch(0, 0, 32'hC000_0002);
    commit(32'h42, 1'b0);
    check_stays_halted(2'd1);

    // Fetch timeout with no response.
    do_reset();
    check("to_addr", imem_addr, addr_q.pop_front());
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_not_yet", {31'h0, halted}, 32'h0);
    end
    step();
    check("to_halted", {31'h0, halted}, 32'h1);
    check("to_cause", {30'h0, halt_cause}, 32'h2);
    check_stays_halted(2'd2);

    // Response on the final allowed wait cycle wins over the timeout.
    do_reset();
    issue_fetch(0, 3, 32'hD000_0001);
    check("late_rsp_halted", {31'h0, halted}, 32'h0);
    commit(32'h104, 1'b0);

    // Reset asserted during EXECUTE together with exec_done discards the commit.
    do_reset();
    issue_fetch(0, 0, 32'hE000_0001);
    commit(32'h104, 1'b0);
    issue_fetch(0, 0, 32'hE000_0002);
    exec_done = 1'b1; new_pc = 32'h108; rst_n = 1'b0;
    step();
    exec_done = 1'b0;
    check("mid_rst_pc", pc, 32'h100);
    check("mid_rst_retired", retired, 32'h0);
    check("mid_rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("mid_rst_redirect", redirect_count, 32'h0);
    rst_n = 1'b1;
    step();
    check("mid_rst_restart", {31'h0, imem_req_valid}, 32'h1);
    check("mid_rst_addr", imem_addr, 32'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
